// File: rtl/press_classifier.sv
// press_classifier
// Turns the debounced button level into gesture events: a short press, a long
// press (held for LONG_CNT cycles) or a double press (second press started
// within GAP_CNT cycles of the release). Every event is a registered
// single-cycle pulse. long_active stays high while a long press is held, and
// busy is high whenever a gesture is in progress.

module press_classifier #(
    parameter int CNT_W    = 24,
    parameter int LONG_CNT = 12000000,
    parameter int GAP_CNT  = 3600000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic long_active,
    output logic busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESSED,
        S_WAIT_GAP,
        S_SECOND_HELD,
        S_LONG_HELD
    } state_t;

    // Terminal counts. The counter starts at 0 on the cycle after a state
    // change, so the terminal value is one less than the cycle count.
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             btn_prev_q;
    logic             short_q;
    logic             long_q;
    logic             double_q;
    logic             active_q;
    logic             busy_q;

    logic             rise;
    logic             fall;

    // Previous button level for edge detection. Resetting it high means a
    // button held through reset looks like "already pressed" and produces
    // no rise until it has been released and pressed again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_q <= 1'b1;
        end else begin
            // NOTE: sequential state is always assigned with <= so every
            // register samples the values from before this clock edge.
            btn_prev_q <= btn_level;
        end
    end

    assign rise = btn_level & ~btn_prev_q;
    assign fall = ~btn_level & btn_prev_q;

    // Gesture FSM with its cycle counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            active_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // NOTE: event pulses default low every cycle; a branch raises one
            // only on the transition that emits it, so each is one cycle wide.
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        state_q <= S_PRESSED;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                S_PRESSED: begin
                    // A release on the terminal cycle still counts as short.
                    if (fall) begin
                        state_q <= S_WAIT_GAP;
                        cnt_q   <= '0;
                    end else if (cnt_q == LONG_LAST) begin
                        state_q  <= S_LONG_HELD;
                        cnt_q    <= '0;
                        long_q   <= 1'b1;
                        active_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                S_WAIT_GAP: begin
                    // A second press on the last gap cycle is still a double.
                    if (rise) begin
                        state_q  <= S_SECOND_HELD;
                        cnt_q    <= '0;
                        double_q <= 1'b1;
                    end else if (cnt_q == GAP_LAST) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        short_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                S_SECOND_HELD: begin
                    // No long detection here; the gesture ends on release.
                    if (fall) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                S_LONG_HELD: begin
                    if (fall) begin
                        state_q  <= S_IDLE;
                        active_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end

                default: begin
                    state_q  <= S_IDLE;
                    cnt_q    <= '0;
                    active_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_press = double_q;
    assign long_active  = active_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier
// Drives button-level waveforms built from runs of high/low cycles, predicts
// every output for every cycle from the gesture rules (run lengths of the
// waveform), and compares cycle by cycle.

module tb_press_classifier;

    localparam int CNT_W    = 8;
    localparam int LONG_CNT = 20;
    localparam int GAP_CNT  = 8;
    localparam int MAXN     = 600;

    // Bit positions in the packed output vector {short,long,double,active,busy}.
    localparam int B_SHORT = 4;
    localparam int B_LONG  = 3;
    localparam int B_DBL   = 2;
    localparam int B_ACT   = 1;
    localparam int B_BUSY  = 0;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_level;
    logic short_press;
    logic long_press;
    logic double_press;
    logic long_active;
    logic busy;

    int checks   = 0;
    int failures = 0;

    bit       stim [MAXN];
    bit [4:0] expv [MAXN];
    int       n;

    press_classifier #(
        .CNT_W   (CNT_W),
        .LONG_CNT(LONG_CNT),
        .GAP_CNT (GAP_CNT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_level   (btn_level),
        .short_press (short_press),
        .long_press  (long_press),
        .double_press(double_press),
        .long_active (long_active),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%05b expected=%05b", tag, obs[4:0], exp[4:0]);
        end
    endtask

    function automatic void push_run(input bit val, input int len);
        for (int j = 0; j < len; j++) begin
            if (n < MAXN) begin
                stim[n] = val;
                n++;
            end
        end
    endfunction

    function automatic int run_len(input int start, input bit val);
        int j;
        j = start;
        while (j < n && stim[j] == val) j++;
        return j - start;
    endfunction

    function automatic void set_range(input int lo, input int hi, input int b);
        for (int c = lo; c <= hi; c++) begin
            if (c >= 0 && c < n) expv[c][b] = 1'b1;
        end
    endfunction

    // Gesture-level reference: walk the waveform rise by rise, measure the
    // hold and gap run lengths, and place events/levels at the cycle indices
    // the gesture rules give (index = value seen while sample index is taken).
    function automatic void build_expect();
        int i;
        int h;
        int f;
        int g;
        int r;
        int h2;
        for (int c = 0; c < MAXN; c++) expv[c] = '0;
        // Index 0 is never a rise: the level just before it counts as high.
        i = 1;
        while (i < n) begin
            if (!(stim[i] && !stim[i-1])) begin
                i++;
            end else begin
                h = run_len(i, 1'b1);
                f = i + h;
                if (h > LONG_CNT) begin
                    set_range(i + LONG_CNT + 1, i + LONG_CNT + 1, B_LONG);
                    set_range(i + LONG_CNT + 1, f, B_ACT);
                    set_range(i + 1, f, B_BUSY);
                    i = f + 1;
                end else begin
                    g = run_len(f, 1'b0);
                    if (g <= GAP_CNT) begin
                        r  = f + g;
                        h2 = run_len(r, 1'b1);
                        set_range(r + 1, r + 1, B_DBL);
                        set_range(i + 1, r + h2, B_BUSY);
                        i = r + h2 + 1;
                    end else begin
                        set_range(f + GAP_CNT + 1, f + GAP_CNT + 1, B_SHORT);
                        set_range(i + 1, f + GAP_CNT, B_BUSY);
                        i = f + GAP_CNT + 1;
                    end
                end
            end
        end
    endfunction

    task automatic run_scenario(input string name);
        build_expect();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s[%0d]", name, i),
                  {short_press, long_press, double_press, long_active, busy}, expv[i]);
            btn_level = stim[i];
        end
    endtask

    task automatic apply_reset(input string name);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check({name, "_in_reset"},
              {short_press, long_press, double_press, long_active, busy}, 32'd0);
        @(negedge clk);
        check({name, "_in_reset2"},
              {short_press, long_press, double_press, long_active, busy}, 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic new_seq();
        n = 0;
        push_run(1'b0, 3);
    endtask

    task automatic end_seq(input string name);
        push_run(1'b0, 40);
        run_scenario(name);
    endtask

    initial begin
        int gestures;
        int hl;
        rst_n     = 1'b0;
        btn_level = 1'b0;
        apply_reset("por");

        // Idle line.
        new_seq(); push_run(1'b0, 50); end_seq("idle");

        // Short press.
        new_seq(); push_run(1'b1, 5); end_seq("short");

        // Long press.
        new_seq(); push_run(1'b1, 30); end_seq("long");

        // Double press.
        new_seq(); push_run(1'b1, 5); push_run(1'b0, 4); push_run(1'b1, 3); end_seq("double");

        // Release exactly on the long terminal cycle, then one cycle later.
        new_seq(); push_run(1'b1, 20); end_seq("rel_cnt19");
        new_seq(); push_run(1'b1, 21); end_seq("hold21");

        // Second rise on the last gap cycle, then one cycle too late.
        new_seq(); push_run(1'b1, 5); push_run(1'b0, 8); push_run(1'b1, 3); end_seq("gap8");
        new_seq(); push_run(1'b1, 5); push_run(1'b0, 9); push_run(1'b1, 5); end_seq("gap9");

        // One-cycle release forms a double press.
        new_seq(); push_run(1'b1, 2); push_run(1'b0, 1); push_run(1'b1, 1); end_seq("gap1");

        // Reset mid-press with the button held, then a long hold that must
        // not classify, then a normal short press.
        new_seq(); push_run(1'b1, 10); run_scenario("pre_reset");
        apply_reset("mid");
        n = 0;
        push_run(1'b1, 100);
        push_run(1'b0, 3);
        push_run(1'b1, 5);
        end_seq("post_reset");

        // Random gesture trains, biased towards the boundaries.
        for (int s = 0; s < 20; s++) begin
            new_seq();
            gestures = $urandom_range(1, 6);
            for (int k = 0; k < gestures; k++) begin
                if ($urandom_range(0, 3) == 0) hl = $urandom_range(19, 22);
                else                            hl = $urandom_range(1, 30);
                push_run(1'b1, hl);
                push_run(1'b0, $urandom_range(1, 11));
            end
            end_seq($sformatf("rand%0d", s));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
